regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised scoreboarded register file; successor to the plain int/float register-file-plus-operand-latch pair in the core datapath.
- Generalises width, depth and read-port count, and adds pending-write tracking so long-latency units (FPU, divider) can run several operations in flight.
- One instance is used per architectural file: int with ZERO_REG=1, float with ZERO_REG=0.
- Replaces the separate read-data latch registers: read data is registered inside the block.

Parameters:
XLEN, 32, data width
NREG, 32, number of registers (power of 2)
NRP, 2, number of read ports
MAXOUT, 4, max outstanding long-latency writes
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
ra  in  NRP*AW  read addresses, port i at [i*AW +: AW]; AW = clog2(NREG)
rd  out  NRP*XLEN  registered read data
rbusy  out  NRP  registered busy flag of each read register
we  in  1  immediate write enable (ALU/mem/imm path)
wa  in  AW  immediate write address
wd  in  XLEN  immediate write data
iss_valid  in  1  long-latency op issued, destination iss_dst
iss_dst  in  AW  destination of issued op
iss_ready  out  1  issue accepted this cycle (combinational)
lwb_valid  in  1  long-latency writeback strobe
lwb_dst  in  AW  writeback address
lwb_data  in  XLEN  writeback data
flush  in  1  synchronous clear of all pending state
outstanding  out  clog2(MAXOUT+1)  current pending count
err  out  1  sticky protocol error

Behaviour:
- Reset, asynchronous on rstn low:
  - all registers = 0, busy = 0, outstanding = 0, err = 0;
  - rd = 0, rbusy = 0.
- Reads:
  - 1-cycle latency: rd[i] at edge t+1 reflects ra[i] sampled at edge t.
  - Write-first bypass: a same-cycle write to ra[i] (lwb over we) forwards the new data.
  - rbusy[i] = busy bit of ra[i] after this cycle's updates.
  - ZERO_REG and ra = 0: rd = 0, rbusy = 0.
- Immediate write:
  - we = 1 writes wd to wa on the clock edge.
  - Ignored for wa = 0 when ZERO_REG.
  - we to a busy register is still performed but sets err (WAW hazard).
- Issue:
  - iss_ready = !busy[iss_dst] && outstanding < MAXOUT && !flush, evaluated on registered state.
  - Accept = iss_valid && iss_ready: sets busy[iss_dst], outstanding += 1.
  - ZERO_REG and iss_dst = 0: iss_ready = 1, no busy set, no count change.
- Writeback:
  - lwb_valid writes lwb_data to lwb_dst.
  - If busy[lwb_dst] = 1: clears it, outstanding -= 1.
  - If busy = 0 and the register is writable: data is still written and err sets.
  - ZERO_REG and dst = 0: silently dropped.
- Simultaneous events:
  - lwb and we to the same address: lwb data wins; err sets, since the register is busy.
  - Issue accept and lwb in the same cycle (necessarily different registers): both applied; outstanding is unchanged net.
  - Issue accept when outstanding = MAXOUT-1 with a same-cycle lwb: allowed, count stays at or below MAXOUT.
- Flush:
  - busy all 0 and outstanding = 0 next edge; register contents retained.
  - Issue is blocked that cycle; lwb and we in the flush cycle still write data but do not set err.
- err is sticky until reset.
- outstanding always equals popcount(busy). An assertion checks this, and checks outstanding <= MAXOUT.

Decomposition:
- Shared package regfile_pkg:
  - function clog2_min1;
  - constants for int/float instance parameter sets (INT_RF: ZERO_REG=1, FP_RF: ZERO_REG=0).
- One natural sub-module, rf_scoreboard: busy vector, outstanding counter, iss_ready, err.
- Storage, bypass and read registers stay in the top.

Test Plan:
- Reset mid-operation: issue to x5, assert rstn low for one cycle with lwb pending -> busy = 0, outstanding = 0, rd = 0, x5 reads 0.
- Bypass: we = 1, wa = 3, wd = 0xDEADBEEF with ra[0] = 3 in the same cycle -> next cycle rd[0] = 0xDEADBEEF, rbusy[0] = 0.
- Scoreboard fill, MAXOUT = 4:
  - issue to x1..x4 -> outstanding = 4; issue to x6 gives iss_ready = 0;
  - lwb x2 = 0x40490FDB -> outstanding = 3, x2 reads 0x40490FDB; x6 issue then accepted.
- WAW / ordering:
  - issue to x7 -> second issue to x7 gives iss_ready = 0;
  - we to x7 -> err = 1;
  - lwb to x9 when not busy -> err stays 1, x9 written.
- Zero register:
  - ZERO_REG = 1: we x0 = 0x1234, lwb x0, issue to x0 -> x0 reads 0, outstanding unchanged, err = 0;
  - ZERO_REG = 0: f0 writable, reads back 0x1234.
- Flush: 3 outstanding, flush pulse with a simultaneous lwb to a busy register -> outstanding = 0, busy all 0, lwb data written, err = 0.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared helpers and per-file parameter sets for the scoreboarded register files.
package regfile_pkg;

    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        int xlen;
        int nreg;
        int nrp;
        int maxout;
        int zero_reg;
    } rf_cfg_t;

    localparam rf_cfg_t INT_RF = '{xlen: 32, nreg: 32, nrp: 2, maxout: 4, zero_reg: 1};
    localparam rf_cfg_t FP_RF  = '{xlen: 32, nreg: 32, nrp: 2, maxout: 4, zero_reg: 0};

endpackage

// File: rtl/regfile_sb_if.sv
// Read, immediate-write, issue and writeback bundle of one register file.
interface regfile_sb_if #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRP    = 2,
    parameter int MAXOUT = 4
);
    import regfile_pkg::*;

    localparam int AW = clog2_min1(NREG);
    localparam int OW = clog2_min1(MAXOUT + 1);

    logic [NRP*AW-1:0]   ra;
    logic [NRP*XLEN-1:0] rd;
    logic [NRP-1:0]      rbusy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                iss_valid;
    logic [AW-1:0]       iss_dst;
    logic                iss_ready;
    logic                lwb_valid;
    logic [AW-1:0]       lwb_dst;
    logic [XLEN-1:0]     lwb_data;
    logic                flush;
    logic [OW-1:0]       outstanding;
    logic                err;

    modport master (
        output ra, we, wa, wd, iss_valid, iss_dst, lwb_valid, lwb_dst, lwb_data, flush,
        input  rd, rbusy, iss_ready, outstanding, err
    );

    modport slave (
        input  ra, we, wa, wd, iss_valid, iss_dst, lwb_valid, lwb_dst, lwb_data, flush,
        output rd, rbusy, iss_ready, outstanding, err
    );

endinterface

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write tracker: busy bits, outstanding count, issue gating and sticky error.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int MAXOUT   = 4,
    parameter int ZERO_REG = 1,
    parameter int AW       = clog2_min1(NREG),
    parameter int OW       = clog2_min1(MAXOUT + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_dst,
    input  logic            lwb_valid,
    input  logic [AW-1:0]   lwb_dst,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic            flush,
    output logic [NREG-1:0] busy_next,
    output logic [OW-1:0]   outstanding,
    output logic            iss_ready,
    output logic            err
);

    logic [NREG-1:0] busy;
    logic [OW-1:0]   outstanding_next;
    logic            accept;
    logic            lwb_hit;
    logic            err_event;

    function automatic logic hardwired(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        iss_ready = 1'b1;
        if (!hardwired(iss_dst))
            iss_ready = !busy[iss_dst] && (outstanding < OW'(MAXOUT)) && !flush;

        accept    = iss_valid && iss_ready && !hardwired(iss_dst);
        lwb_hit   = lwb_valid && !hardwired(lwb_dst) && busy[lwb_dst];
        err_event = !flush &&
                    ((lwb_valid && !hardwired(lwb_dst) && !busy[lwb_dst]) ||
                     (we && !hardwired(wa) && busy[wa]));

        busy_next        = busy;
        outstanding_next = outstanding;
        if (flush) begin
            busy_next        = '0;
            outstanding_next = '0;
        end else begin
            // Clear before set: an issue to a non-busy register must survive a stray writeback to it.
            if (lwb_hit) busy_next[lwb_dst] = 1'b0;
            if (accept)  busy_next[iss_dst] = 1'b1;
            outstanding_next = outstanding + OW'(accept) - OW'(lwb_hit);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy        <= '0;
            outstanding <= '0;
            err         <= 1'b0;
        end else begin
            busy        <= busy_next;
            outstanding <= outstanding_next;
            err         <= err | err_event;
        end
    end

    assert property (@(posedge clk) disable iff (!rstn) int'(outstanding) == $countones(busy));
    assert property (@(posedge clk) disable iff (!rstn) int'(outstanding) <= MAXOUT);

endmodule

// File: rtl/regfile_sb.sv
// Scoreboarded register file: storage, write-first read bypass and registered read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRP      = 2,
    parameter int MAXOUT   = 4,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rstn,
    regfile_sb_if.slave bus
);

    localparam int AW = clog2_min1(NREG);
    localparam int OW = clog2_min1(MAXOUT + 1);

    logic [XLEN-1:0]     regs [NREG];
    logic [NREG-1:0]     busy_next;
    logic                wr_imm;
    logic                wr_lwb;
    logic [NRP*XLEN-1:0] rd_next;
    logic [NRP-1:0]      rbusy_next;

    function automatic logic hardwired(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    rf_scoreboard #(
        .NREG     (NREG),
        .MAXOUT   (MAXOUT),
        .ZERO_REG (ZERO_REG),
        .AW       (AW),
        .OW       (OW)
    ) u_sb (
        .clk         (clk),
        .rstn        (rstn),
        .iss_valid   (bus.iss_valid),
        .iss_dst     (bus.iss_dst),
        .lwb_valid   (bus.lwb_valid),
        .lwb_dst     (bus.lwb_dst),
        .we          (bus.we),
        .wa          (bus.wa),
        .flush       (bus.flush),
        .busy_next   (busy_next),
        .outstanding (bus.outstanding),
        .iss_ready   (bus.iss_ready),
        .err         (bus.err)
    );

    assign wr_imm = bus.we && !hardwired(bus.wa);
    assign wr_lwb = bus.lwb_valid && !hardwired(bus.lwb_dst);

    // Later assignments override earlier ones, giving writeback priority over the immediate write.
    always_comb begin
        rd_next    = '0;
        rbusy_next = '0;
        for (int p = 0; p < NRP; p++) begin
            if (!hardwired(bus.ra[p*AW +: AW])) begin
                rd_next[p*XLEN +: XLEN] = regs[bus.ra[p*AW +: AW]];
                if (wr_imm && bus.wa == bus.ra[p*AW +: AW])
                    rd_next[p*XLEN +: XLEN] = bus.wd;
                if (wr_lwb && bus.lwb_dst == bus.ra[p*AW +: AW])
                    rd_next[p*XLEN +: XLEN] = bus.lwb_data;
                rbusy_next[p] = busy_next[bus.ra[p*AW +: AW]];
            end
        end
    end

    // NOTE: storage is reset explicitly because every register must read as zero after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            bus.rd    <= '0;
            bus.rbusy <= '0;
        end else begin
            if (wr_imm) regs[bus.wa]      <= bus.wd;
            if (wr_lwb) regs[bus.lwb_dst] <= bus.lwb_data;
            bus.rd    <= rd_next;
            bus.rbusy <= rbusy_next;
        end
    end

endmodule
